// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: ALU and multi-cycle result inputs,
// registered regfile write port and status outputs.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_waddr;
  logic [31:0] mc_wdata;
  logic        wena;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        alu_stall;
  logic [31:0] pend_mask;
  logic [1:0]  q_count;

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, mc_valid, mc_waddr, mc_wdata,
    output mc_ready, wena, waddr, wdata, alu_stall, pend_mask, q_count
  );

  modport master (
    output alu_valid, alu_waddr, alu_wdata, mc_valid, mc_waddr, mc_wdata,
    input  mc_ready, wena, waddr, wdata, alu_stall, pend_mask, q_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the un-stallable ALU result stream with a 2-entry
// queue of multi-cycle results onto one registered regfile write port.
module wb_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input logic       clk,
  input logic       rst,
  wb_arbiter_if.slave bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  // Queue is kept compacted: entry 0 is the head, entry 1 valid only if entry 0 is.
  logic [1:0]  q_vld, n_vld;
  logic [4:0]  q_addr [2];
  logic [4:0]  n_addr [2];
  logic [31:0] q_data [2];
  logic [31:0] n_data [2];

  logic [SW-1:0] starve_cnt, n_starve;
  logic          stall_q, n_stall;
  logic          wena_q, n_wena;
  logic [4:0]    waddr_q, n_waddr;
  logic [31:0]   wdata_q, n_wdata;
  logic [31:0]   pend_q, n_pend;

  logic       alu_win, mc_acc, mc_keep, q_empty, pop, bypass, push;
  logic [1:0] surv;

  assign bus.mc_ready  = !(q_vld[0] && q_vld[1]);
  assign bus.q_count   = {q_vld[0] & q_vld[1], q_vld[0] ^ q_vld[1]};
  assign bus.wena      = wena_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.alu_stall = stall_q;
  assign bus.pend_mask = pend_q;

  always_comb begin
    alu_win = bus.alu_valid && !stall_q && (bus.alu_waddr != 5'd0);
    mc_acc  = bus.mc_valid && bus.mc_ready;
    // An mc result to the register the winning ALU writes is already stale.
    mc_keep = mc_acc && (bus.mc_waddr != 5'd0) &&
              !(alu_win && (bus.mc_waddr == bus.alu_waddr));
    q_empty = !q_vld[0];
    for (int i = 0; i < 2; i++)
      surv[i] = q_vld[i] && !(alu_win && (q_addr[i] == bus.alu_waddr));
    pop    = !alu_win && !q_empty;
    bypass = !alu_win && q_empty && mc_keep;
    push   = mc_keep && !bypass;

    n_vld  = 2'b00;
    n_addr = q_addr;
    n_data = q_data;
    if (pop) begin
      n_vld[0]  = q_vld[1];
      n_addr[0] = q_addr[1];
      n_data[0] = q_data[1];
    end else if (surv[0]) begin
      n_vld[0] = 1'b1;
      n_vld[1] = surv[1];
    end else if (surv[1]) begin
      n_vld[0]  = 1'b1;
      n_addr[0] = q_addr[1];
      n_data[0] = q_data[1];
    end
    if (push) begin
      if (!n_vld[0]) begin
        n_vld[0]  = 1'b1;
        n_addr[0] = bus.mc_waddr;
        n_data[0] = bus.mc_wdata;
      end else begin
        n_vld[1]  = 1'b1;
        n_addr[1] = bus.mc_waddr;
        n_data[1] = bus.mc_wdata;
      end
    end

    n_wena  = alu_win || pop || bypass;
    n_waddr = waddr_q;
    n_wdata = wdata_q;
    if (alu_win) begin
      n_waddr = bus.alu_waddr;
      n_wdata = bus.alu_wdata;
    end else if (pop) begin
      n_waddr = q_addr[0];
      n_wdata = q_data[0];
    end else if (bypass) begin
      n_waddr = bus.mc_waddr;
      n_wdata = bus.mc_wdata;
    end

    if (pop || q_empty)
      n_starve = '0;
    else if (alu_win)
      n_starve = starve_cnt + SW'(1);
    else
      n_starve = starve_cnt;
    // No point stalling the ALU if nothing is left queued to drain.
    n_stall = (n_starve == SW'(STARVE_MAX)) && n_vld[0];

    n_pend = '0;
    for (int i = 0; i < 2; i++)
      if (n_vld[i]) n_pend = n_pend | (32'(1) << n_addr[i]);
    if (n_wena) n_pend = n_pend | (32'(1) << n_waddr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_vld      <= 2'b00;
      q_addr[0]  <= '0;
      q_addr[1]  <= '0;
      q_data[0]  <= '0;
      q_data[1]  <= '0;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      wena_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
    end else begin
      q_vld      <= n_vld;
      q_addr[0]  <= n_addr[0];
      q_addr[1]  <= n_addr[1];
      q_data[0]  <= n_data[0];
      q_data[1]  <= n_data[1];
      starve_cnt <= n_starve;
      stall_q    <= n_stall;
      wena_q     <= n_wena;
      waddr_q    <= n_waddr;
      wdata_q    <= n_wdata;
      pend_q     <= n_pend;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vectors with hand-computed
// registered outputs, plus starvation and mid-traffic reset sequences.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();
  wb_arbiter #(.STARVE_MAX(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [1:0]  eq;
    logic        er;
    logic [31:0] epm;
    logic        es;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] b(int n);
    return 32'(1) << n;
  endfunction

  function automatic vec_t mk(bit av, int aa, int ad, bit mv, int ma, int md,
                              bit ew, int ea, int ed, int eq, bit er,
                              logic [31:0] epm, bit es);
    vec_t v;
    v.av = av;  v.aa = 5'(aa);  v.ad = 32'(ad);
    v.mv = mv;  v.ma = 5'(ma);  v.md = 32'(md);
    v.ew = ew;  v.ea = 5'(ea);  v.ed = 32'(ed);
    v.eq = 2'(eq); v.er = er;   v.epm = epm; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid = v.av;
    bus.alu_waddr = v.aa;
    bus.alu_wdata = v.ad;
    bus.mc_valid  = v.mv;
    bus.mc_waddr  = v.ma;
    bus.mc_wdata  = v.md;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, ".wena"},      32'(bus.wena),      32'(v.ew));
    if (v.ew) begin
      chk({tag, ".waddr"},   32'(bus.waddr),     32'(v.ea));
      chk({tag, ".wdata"},   bus.wdata,          v.ed);
    end
    chk({tag, ".q_count"},   32'(bus.q_count),   32'(v.eq));
    chk({tag, ".mc_ready"},  32'(bus.mc_ready),  32'(v.er));
    chk({tag, ".pend_mask"}, bus.pend_mask,      v.epm);
    chk({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(v.es));
  endtask

  vec_t tv[$];
  vec_t sv[$];
  vec_t idle;

  initial begin
    idle = mk(0,0,0, 0,0,0, 0,0,0, 0,1, 32'h0, 0);
    drive(idle);

    //           av aa  ad      mv ma md      ew ea ed      q rdy pend             stall
    tv.push_back(mk(1, 5, 'h11,  0, 0, 0,      1, 5, 'h11,  0, 1, b(5),            0)); // alu direct
    tv.push_back(mk(0, 0, 0,     1, 7, 'hAB,   1, 7, 'hAB,  0, 1, b(7),            0)); // mc bypass
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0, 0,     0, 1, 32'h0,           0));
    tv.push_back(mk(1, 0, 'h77,  1, 0, 'h55,   0, 0, 0,     0, 1, 32'h0,           0)); // both addr 0
    tv.push_back(mk(1, 3, 'h33,  1, 4, 'h1,    1, 3, 'h33,  1, 1, b(3)|b(4),       0)); // 4 queued
    tv.push_back(mk(1, 4, 'h2,   0, 0, 0,      1, 4, 'h2,   0, 1, b(4),            0)); // supersedes
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0, 0,     0, 1, 32'h0,           0));
    tv.push_back(mk(0, 0, 0,     1, 0, 'h5,    0, 0, 0,     0, 1, 32'h0,           0)); // mc addr 0
    tv.push_back(mk(1, 6, 'h66,  1, 6, 'h99,   1, 6, 'h66,  0, 1, b(6),            0)); // same-cycle clash
    tv.push_back(mk(1, 0, 'h44,  1, 9, 'h9,    1, 9, 'h9,   0, 1, b(9),            0)); // alu addr 0 loses
    tv.push_back(mk(1, 11,'hB0,  1, 10,'hA0,   1, 11,'hB0,  1, 1, b(11)|b(10),     0));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 10,'hA0,  0, 1, b(10),           0));
    tv.push_back(mk(1, 1, 'h1,   1, 12,'hC,    1, 1, 'h1,   1, 1, b(1)|b(12),      0));
    tv.push_back(mk(0, 0, 0,     1, 13,'hD,    1, 12,'hC,   1, 1, b(12)|b(13),     0)); // push+pop
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      1, 13,'hD,   0, 1, b(13),           0));
    tv.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0, 0,     0, 1, 32'h0,           0));

    // Starvation: ALU streams continuously, upstream repeats the address it lost to a stall.
    sv.push_back(mk(1, 1, 'h101, 1, 8, 'hC8,   1, 1, 'h101, 1, 1, b(1)|b(8),       0));
    sv.push_back(mk(1, 2, 'h102, 1, 9, 'hC9,   1, 2, 'h102, 2, 0, b(2)|b(8)|b(9),  0));
    sv.push_back(mk(1, 3, 'h103, 1, 10,'hCA,   1, 3, 'h103, 2, 0, b(3)|b(8)|b(9),  0)); // mc not accepted
    sv.push_back(mk(1, 4, 'h104, 0, 0, 0,      1, 4, 'h104, 2, 0, b(4)|b(8)|b(9),  1));
    sv.push_back(mk(1, 5, 'h105, 0, 0, 0,      1, 8, 'hC8,  1, 1, b(8)|b(9),       0)); // alu ignored
    sv.push_back(mk(1, 5, 'h105, 0, 0, 0,      1, 5, 'h105, 1, 1, b(5)|b(9),       0));
    sv.push_back(mk(1, 6, 'h106, 0, 0, 0,      1, 6, 'h106, 1, 1, b(6)|b(9),       0));
    sv.push_back(mk(1, 7, 'h107, 0, 0, 0,      1, 7, 'h107, 1, 1, b(7)|b(9),       1));
    sv.push_back(mk(1, 8, 'h108, 0, 0, 0,      1, 9, 'hC9,  0, 1, b(9),            0)); // alu ignored
    sv.push_back(mk(1, 8, 'h108, 0, 0, 0,      1, 8, 'h108, 0, 1, b(8),            0));
    sv.push_back(mk(0, 0, 0,     0, 0, 0,      0, 0, 0,     0, 1, 32'h0,           0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.wena",      32'(bus.wena),      32'h0);
    chk("reset.waddr",     32'(bus.waddr),     32'h0);
    chk("reset.wdata",     bus.wdata,          32'h0);
    chk("reset.q_count",   32'(bus.q_count),   32'h0);
    chk("reset.pend_mask", bus.pend_mask,      32'h0);
    chk("reset.alu_stall", 32'(bus.alu_stall), 32'h0);
    rst = 1'b1;
    chk("reset.mc_ready",  32'(bus.mc_ready),  32'h1);

    for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("vec%0d", i));
    for (int i = 0; i < sv.size(); i++) apply(sv[i], $sformatf("starve%0d", i));

    // Fill the queue, then reset with a result in flight.
    apply(mk(1, 1, 'h101, 1, 20, 'hD0,  1, 1, 'h101, 1, 1, b(1)|b(20),         0), "fill0");
    apply(mk(1, 2, 'h102, 1, 21, 'hD1,  1, 2, 'h102, 2, 0, b(2)|b(20)|b(21),   0), "fill1");
    rst = 1'b0;
    drive(mk(1, 3, 'h103, 0, 0, 0,      0, 0, 0,     0, 1, 32'h0, 0));
    @(posedge clk);
    #1;
    chk("mid_reset.wena",      32'(bus.wena),      32'h0);
    chk("mid_reset.waddr",     32'(bus.waddr),     32'h0);
    chk("mid_reset.wdata",     bus.wdata,          32'h0);
    chk("mid_reset.q_count",   32'(bus.q_count),   32'h0);
    chk("mid_reset.mc_ready",  32'(bus.mc_ready),  32'h1);
    chk("mid_reset.pend_mask", bus.pend_mask,      32'h0);
    chk("mid_reset.alu_stall", 32'(bus.alu_stall), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply(idle, $sformatf("post_reset%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, consecutive cycles a queued result may lose arbitration before alu_stall asserts.
REQ-002 SHALL have ports, as name  direction  width  meaning:
  clk  in  1  single clock for all state.
  rst  in  1  reset; synchronous, active-low.
  alu_valid  in  1  single-cycle ALU result present; cannot be back-pressured.
  alu_waddr  in  5  ALU destination register.
  alu_wdata  in  32  ALU result.
  mc_valid  in  1  multi-cycle (mul/div/load) result offered.
  mc_ready  out  1  block accepts mc result this cycle.
  mc_waddr  in  5  multi-cycle destination register.
  mc_wdata  in  32  multi-cycle result.
  wena  out  1  registered regfile write enable.
  waddr  out  5  registered regfile write address.
  wdata  out  32  registered regfile write data.
  alu_stall  out  1  registered request to upstream to withhold alu_valid.
  pend_mask  out  32  bit i set when a queued or in-flight output write targets register i.
  q_count  out  2  queue occupancy, 0..2.

Function
REQ-003 SHALL hold a 2-entry FIFO (addr, data) for accepted multi-cycle results.
REQ-004 SHALL drive mc_ready = (q_count < 2), combinational from current occupancy only.
REQ-005 SHALL accept an mc result on the cycle mc_valid && mc_ready.
REQ-006 SHALL discard an accepted mc result with mc_waddr = 0: no queue slot used, no write.
REQ-007 SHALL ignore alu_valid with alu_waddr = 0: it consumes no output slot.
REQ-008 SHALL, each cycle, load the output register by priority:
  (a) ALU result, if alu_valid, alu_stall = 0, and alu_waddr != 0;
  (b) else the queue head, popped;
  (c) else an mc result accepted this cycle while the queue is empty, bypassing the FIFO;
  (d) else wena = 0.
REQ-009 SHALL give latency of one clock from input acceptance to wena for cases (a) and (c).
REQ-010 SHALL allow push and pop in the same cycle; q_count then stays unchanged.
REQ-011 SHALL invalidate any queued entry whose addr equals alu_waddr on the cycle an ALU result wins (younger write supersedes); occupancy drops accordingly.
REQ-012 SHALL NOT enqueue an mc result accepted on that same cycle if it targets that same register; it is discarded.
REQ-013 SHALL keep a starvation counter:
  - increments each cycle the queue is non-empty and an ALU result wins;
  - clears when the queue head is popped or the queue is empty.
REQ-014 SHALL set alu_stall for exactly one cycle on the cycle after the counter reaches STARVE_MAX; during that cycle alu_valid is ignored and the queue head wins.
REQ-015 SHALL make pend_mask the OR of one-hot decodes of valid queue entries plus waddr when wena = 1, updated with registered state.
REQ-016 SHALL have the regfile see every write exactly once, in arbitration order; no result is lost except by REQ-006, REQ-007, REQ-011 and REQ-012.

Reset
REQ-017 SHALL, when rst = 0 at a clk edge, clear the queue, starvation counter, wena, waddr, wdata, alu_stall, pend_mask and q_count to 0.
REQ-018 SHALL drop results in flight at reset; mc_ready = 1 on the first cycle after rst returns to 1.

Verification
REQ-019 SHALL pass: alu_valid with addr 5, data 0x11 -> next cycle wena = 1, waddr = 5, wdata = 0x11; pend_mask[5] = 1 for that cycle.
REQ-020 SHALL pass: mc_valid with addr 7, data 0xAB, queue empty, no ALU -> next cycle wena = 1, waddr = 7; q_count stays 0.
REQ-021 SHALL pass: alu_valid held high with addrs 1, 2, ...; two mc results to addrs 8 and 9 -> q_count = 2 and mc_ready = 0; alu_stall = 1 after 3 lost cycles; addr 8 written, then a further stall and addr 9 written.
REQ-022 SHALL pass: queue holds addr 4 (data 0x1); ALU writes addr 4 (data 0x2) -> only 0x2 written; q_count decrements; pend_mask[4] clears after the output cycle.
REQ-023 SHALL pass: mc push to addr 0 and alu_valid to addr 0 -> wena stays 0; q_count stays 0.
REQ-024 SHALL pass: rst = 0 asserted with q_count = 2 -> next cycle all outputs 0, mc_ready = 1, and the queued writes never appear.
